// File: rtl/channel_sample_buffer_pkg.sv
// Shared definitions for the per-channel sample buffer and its acquisition state machine.
package channel_sample_buffer_pkg;

  // Default sample width and buffer address width, shared with the channel state machine.
  localparam int unsigned CSB_DATA_W = 12;
  localparam int unsigned CSB_ADDR_W = 10;

  // Buffer control states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    HOLD    = 3'd2,
    READ    = 3'd3,
    DONE    = 3'd4
  } csb_state_e;

endpackage

// File: rtl/channel_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (1-cycle latency).
module channel_sdp_ram
  import channel_sample_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = CSB_DATA_W,
  parameter int unsigned ADDR_W = CSB_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/channel_sample_buffer.sv
// Per-channel circular sample buffer: captures ADC samples, freezes on trigger and
// streams the most recent READ_LEN samples oldest-first over valid/ready.
module channel_sample_buffer
  import channel_sample_buffer_pkg::*;
#(
  parameter int unsigned DATA_W   = CSB_DATA_W,
  parameter int unsigned ADDR_W   = CSB_ADDR_W,
  parameter int unsigned READ_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              wr_enable,
  input  logic              ro_enable,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              rodone_n,
  output logic [ADDR_W:0]   fill_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] READ_LEN_C = CNT_W'(READ_LEN);

  csb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  n_c;

  logic              ram_we_c;
  logic              ram_re_c;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;

  logic              flush_c;
  logic              pop_c;
  logic              push_c;
  logic [1:0]        credit_c;
  logic              issue_ok_c;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic              skid_last_q, skid_last_d;
  logic              rodone_n_q, rodone_n_d;

  channel_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .waddr_i (wptr_q),
    .wdata_i (adc_data),
    .re_i    (ram_re_c),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  // Readout length is the held sample count clipped to READ_LEN.
  assign n_c = (fill_q < READ_LEN_C) ? fill_q : READ_LEN_C;

  // A read may only be issued if its data is guaranteed a skid slot when it lands:
  // held entries plus the in-flight read, minus this cycle's pop, must leave room.
  assign pop_c      = dout_valid_q & dout_ready;
  assign push_c     = rd_vld_q & (state_q == READ);
  assign credit_c   = 2'(dout_valid_q) + 2'(skid_vld_q) + 2'(rd_vld_q) - 2'(pop_c);
  assign issue_ok_c = (credit_c <= 2'd1);

  // Next-state, pointer and fill control.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    ram_we_c = 1'b0;
    ram_re_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_enable) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!wr_enable) begin
          state_d = HOLD;
        end else if (adc_valid) begin
          ram_we_c = 1'b1;
          wptr_d   = wptr_q + ADDR_W'(1);
          if (fill_q != DEPTH_C) begin
            fill_d = fill_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (ro_enable) begin
          if (n_c == '0) begin
            state_d = DONE;
            fill_d  = '0;
          end else begin
            state_d = READ;
            rptr_d  = wptr_q - ADDR_W'(n_c);
            rem_d   = n_c;
          end
        end else if (wr_enable) begin
          state_d = CAPTURE;
        end
      end
      READ: begin
        if (!ro_enable) begin
          state_d = IDLE;
          flush_c = 1'b1;
          fill_d  = '0;
          rem_d   = '0;
        end else begin
          if (issue_ok_c && (rem_q != '0)) begin
            ram_re_c = 1'b1;
            rptr_d   = rptr_q + ADDR_W'(1);
            rem_d    = rem_q - CNT_W'(1);
          end
          if (pop_c && dout_last_q) begin
            state_d = DONE;
            fill_d  = '0;
          end
        end
      end
      DONE: begin
        fill_d = '0;
        if (!ro_enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rd_vld_d   = ram_re_c;
    rd_last_d  = ram_re_c & (rem_q == CNT_W'(1));
    rodone_n_d = (state_d != DONE);
  end

  // Two-entry output skid: head register drives dout, spare absorbs the in-flight read.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    skid_d       = skid_q;
    skid_vld_d   = skid_vld_q;
    skid_last_d  = skid_last_q;
    if (flush_c) begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      skid_vld_d   = 1'b0;
      skid_last_d  = 1'b0;
    end else if (!dout_valid_q || pop_c) begin
      if (skid_vld_q) begin
        dout_d       = skid_q;
        dout_valid_d = 1'b1;
        dout_last_d  = skid_last_q;
        skid_vld_d   = push_c;
        skid_last_d  = push_c & rd_last_q;
        if (push_c) begin
          skid_d = ram_rdata;
        end
      end else begin
        dout_valid_d = push_c;
        dout_last_d  = push_c & rd_last_q;
        if (push_c) begin
          dout_d = ram_rdata;
        end
      end
    end else if (push_c) begin
      skid_d      = ram_rdata;
      skid_vld_d  = 1'b1;
      skid_last_d = rd_last_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fill_q       <= '0;
      rem_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      skid_q       <= '0;
      skid_vld_q   <= 1'b0;
      skid_last_q  <= 1'b0;
      rodone_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fill_q       <= fill_d;
      rem_q        <= rem_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      skid_q       <= skid_d;
      skid_vld_q   <= skid_vld_d;
      skid_last_q  <= skid_last_d;
      rodone_n_q   <= rodone_n_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign rodone_n   = rodone_n_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_channel_sample_buffer.sv
// Scoreboard bench for channel_sample_buffer against a queue-based history model.
module tb_channel_sample_buffer;

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned READ_LEN = 256;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              wr_enable;
  logic              ro_enable;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              rodone_n;
  logic [ADDR_W:0]   fill_count;

  channel_sample_buffer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .READ_LEN (READ_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .wr_enable  (wr_enable),
    .ro_enable  (ro_enable),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .rodone_n   (rodone_n),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   hist[$];        // samples held since last readout, newest at back
  exp_t exp_q[$];       // scoreboard of samples the DUT still owes
  int   hs_cnt = 0;
  int   ro_req_cyc = 0;
  int   first_valid_cyc = 0;
  int   last_hs_cyc = 0;
  int   exp_n = 0;
  bit   first_pending = 0;
  bit   tput_chk = 0;
  bit   prev_stall = 0;
  int   hold_d = 0;
  int   hold_l = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk_eq("stall_valid", int'(dout_valid), 1);
        chk_eq("stall_data", int'(dout), hold_d);
        chk_eq("stall_last", int'(dout_last), hold_l);
      end
      prev_stall = dout_valid && !dout_ready;
      hold_d = int'(dout);
      hold_l = int'(dout_last);
      if (dout_valid && first_pending) begin
        first_pending = 0;
        first_valid_cyc = cyc;
        chk_eq("first_valid_latency", cyc - ro_req_cyc, 3);
      end
      if (exp_q.size() == 0) begin
        if (dout_valid) chk_eq("spurious_valid", int'(dout_valid), 0);
      end else begin
        if (tput_chk) chk_eq("throughput_valid", int'(dout_valid), 1);
        if (dout_valid && dout_ready) begin
          mon_e = exp_q.pop_front();
          chk_eq("dout_data", int'(dout), int'(mon_e.data));
          chk_eq("dout_last", int'(dout_last), int'(mon_e.last));
          hs_cnt++;
          if (mon_e.last) last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture count samples; mode 0 sequential, 1 random data with gaps, 2 sequential with gaps.
  task automatic capture(input int count, input int mode, input int base);
    int i;
    i = 0;
    wr_enable = 1'b1;
    adc_valid = 1'b0;
    step();
    while (i < count) begin
      if (mode != 0 && $urandom_range(3) == 0) begin
        adc_valid = 1'b0;
      end else begin
        adc_valid = 1'b1;
        adc_data  = (mode == 1) ? DATA_W'($urandom) : DATA_W'(base + i);
        hist.push_back(int'(adc_data));
        if (hist.size() > DEPTH) void'(hist.pop_front());
        i++;
      end
      step();
    end
    // Sample coinciding with wr_enable falling must be dropped.
    wr_enable = 1'b0;
    adc_valid = 1'b1;
    adc_data  = DATA_W'($urandom);
    step();
    adc_valid = 1'b0;
    chk_eq("fill_count_hold", int'(fill_count), hist.size());
  endtask

  task automatic readout_go(input bit also_wr);
    int n;
    n = (hist.size() < READ_LEN) ? hist.size() : READ_LEN;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: DATA_W'(hist[hist.size() - n + i]), last: (i == n - 1)});
    end
    hist.delete();
    exp_n = n;
    first_pending = (n > 0);
    ro_req_cyc = cyc;
    ro_enable = 1'b1;
    if (also_wr) begin
      wr_enable = 1'b1;
      adc_valid = 1'b1;
      adc_data  = DATA_W'($urandom);
    end
  endtask

  task automatic readout_finish(input int rand_cycles);
    int k;
    bit done;
    k = 0;
    done = 0;
    while (!done && k < 5000) begin
      dout_ready = (k < rand_cycles) ? 1'($urandom_range(1)) : 1'b1;
      step();
      k++;
      if (k > rand_cycles + 3) tput_chk = 1;
      if (!rodone_n) done = 1;
    end
    tput_chk = 0;
    chk_eq("rodone_timeout", int'(done), 1);
    if (exp_n > 0) chk_eq("rodone_after_last", cyc - last_hs_cyc, 1);
    else chk_eq("rodone_empty", cyc - ro_req_cyc, 1);
    chk_eq("queue_drained", exp_q.size(), 0);
    chk_eq("fill_in_done", int'(fill_count), 0);
    if (exp_n > 0 && rand_cycles == 0) chk_eq("burst_length", last_hs_cyc - first_valid_cyc, exp_n - 1);
    step();
    chk_eq("rodone_held", int'(rodone_n), 0);
    ro_enable = 1'b0;
    wr_enable = 1'b0;
    adc_valid = 1'b0;
    step();
    chk_eq("rodone_release", int'(rodone_n), 1);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    wr_enable = 1'b0; ro_enable = 1'b0; adc_valid = 1'b0;
    adc_data = '0; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("rst_dout_valid", int'(dout_valid), 0);
    chk_eq("rst_dout_last", int'(dout_last), 0);
    chk_eq("rst_dout", int'(dout), 0);
    chk_eq("rst_rodone_n", int'(rodone_n), 1);
    chk_eq("rst_fill", int'(fill_count), 0);
    #2 rst_n = 1'b1;
    step();

    // Basic capture 0..299, read 44..299 at full rate.
    capture(300, 0, 0);
    readout_go(0);
    readout_finish(0);

    // Short fill, wr_enable and ro_enable high together.
    capture(10, 0, 100);
    readout_go(1);
    readout_finish(0);

    // Wrap with saturation and a HOLD->CAPTURE resume.
    capture(600, 2, 0);
    capture(500, 2, 600);
    chk_eq("fill_saturated", int'(fill_count), DEPTH);
    readout_go(0);
    readout_finish(0);

    // Random backpressure then ready held high.
    capture(400, 1, 0);
    readout_go(0);
    readout_finish(150);

    // Abort mid-read.
    capture(100, 1, 0);
    readout_go(0);
    dout_ready = 1'b1;
    base = hs_cnt;
    k = 0;
    while (hs_cnt < base + 5 && k < 100) begin step(); k++; end
    chk_eq("abort_progress", int'(hs_cnt - base >= 5), 1);
    ro_enable = 1'b0;
    step();
    chk_eq("abort_valid", int'(dout_valid), 0);
    chk_eq("abort_rodone", int'(rodone_n), 1);
    chk_eq("abort_fill", int'(fill_count), 0);
    exp_q.delete();
    first_pending = 0;
    step();
    chk_eq("abort_rodone_after", int'(rodone_n), 1);
    hist.delete();

    // Empty readout.
    capture(0, 0, 0);
    readout_go(0);
    readout_finish(0);

    // Asynchronous reset in the middle of a read.
    capture(300, 1, 0);
    readout_go(0);
    base = hs_cnt;
    k = 0;
    while (hs_cnt < base + 20 && k < 400) begin
      dout_ready = 1'($urandom_range(1));
      step();
      k++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", int'(dout_valid), 0);
    chk_eq("arst_rodone", int'(rodone_n), 1);
    chk_eq("arst_fill", int'(fill_count), 0);
    chk_eq("arst_last", int'(dout_last), 0);
    ro_enable = 1'b0;
    dout_ready = 1'b1;
    exp_q.delete();
    hist.delete();
    first_pending = 0;
    step();
    step();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    capture(20, 1, 0);
    readout_go(0);
    readout_finish(0);

    // A few random rounds.
    for (int r = 0; r < 3; r++) begin
      capture(int'($urandom_range(1, 300)), 1, 0);
      readout_go(0);
      readout_finish(int'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
